// File: rtl/dma_engine.sv
// dma_engine: single-block DMA responder splitting a DATA_W block into BUS_W beats on a req/ack bus.
module dma_engine #(
    parameter int DATA_W  = 1024,
    parameter int BUS_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx_start,
    input  logic [31:0]       rx_address,
    output logic [DATA_W-1:0] rx_data,
    input  logic              tx_start,
    input  logic [31:0]       tx_address,
    input  logic [DATA_W-1:0] tx_data,
    output logic              done,
    output logic              idle,
    output logic              error,
    output logic              m_req,
    output logic              m_we,
    output logic [31:0]       m_addr,
    output logic [BUS_W-1:0]  m_wdata,
    input  logic              m_ack,
    input  logic [BUS_W-1:0]  m_rdata,
    input  logic              m_err
);
    localparam int BEATS = DATA_W / BUS_W;
    localparam int KW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int OW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t state, state_n;
    logic [31:0] base;
    logic [KW-1:0] k;
    logic [TW-1:0] tcnt;
    logic [OW-1:0] off;
    logic [31:0] sel_addr;
    logic start, busy, last, tout;

    assign start = rx_start | tx_start;
    assign sel_addr = rx_start ? rx_address : tx_address;
    assign busy = state == READ || state == WRITE;
    assign last = k == KW'(BEATS - 1);
    assign tout = tcnt == TW'(TIMEOUT - 1);
    assign off = OW'(k) * OW'(BUS_W);

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        idle = state == IDLE;
        done = state == DONE;
        m_req = busy;
        m_we = state == WRITE;
        m_addr = busy ? base + (32'(k) << 2) : '0;
        m_wdata = state == WRITE ? tx_data[off +: BUS_W] : '0;
        if (state == IDLE && start)
            state_n = |sel_addr[1:0] ? DONE : rx_start ? READ : WRITE;
        else if (busy && (m_err || (m_ack && last) || (!m_ack && tout)))
            state_n = DONE;
        else if (state == DONE)
            state_n = IDLE;
    end

    // m_err wins over m_ack; a stalled beat only ages the timeout counter
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            base <= '0;
            k <= '0;
            tcnt <= '0;
            error <= 1'b0;
            rx_data <= '0;
        end else if (state == IDLE && start) begin
            base <= sel_addr;
            k <= '0;
            tcnt <= '0;
            error <= |sel_addr[1:0];
        end else if (busy) begin
            if (m_err) error <= 1'b1;
            else if (m_ack) begin
                k <= k + KW'(1);
                tcnt <= '0;
                if (state == READ) rx_data[off +: BUS_W] <= m_rdata;
            end else begin
                tcnt <= tcnt + TW'(1);
                if (tout) error <= 1'b1;
            end
        end
endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: table-driven transfers against a word-addressed memory responder, plus reset corner cases.
module tb_dma_engine;
    logic clk = 0, resetn = 0, rx_start = 0, tx_start = 0, m_ack = 0, m_err = 0;
    logic [31:0] rx_address = 0, tx_address = 0, m_addr, m_rdata = 0, m_wdata;
    logic [1023:0] rx_data, tx_data, exp_rx = '0;
    logic done, idle, error, m_req, m_we;
    int checks = 0, errors = 0;
    logic [31:0] mem [0:4095];
    int mode = 0, beats_seen = 0, req_seen = 0;
    logic [31:0] err_addr = '1, cur_base = 0;
    logic cur_we = 0, prev_req = 0, prev_ack = 0;
    logic [64:0] prev_bus = '0;

    typedef struct {
        logic rx;
        logic tx;
        logic [31:0] rx_addr;
        logic [31:0] tx_addr;
        int mode;
        logic [31:0] err_addr;
        int exp_cyc;
        logic exp_err;
        int beats;
    } vec_t;
    vec_t vecs[9];

    always #5 clk = ~clk;

    dma_engine dut (
        .clk(clk), .resetn(resetn),
        .rx_start(rx_start), .rx_address(rx_address), .rx_data(rx_data),
        .tx_start(tx_start), .tx_address(tx_address), .tx_data(tx_data),
        .done(done), .idle(idle), .error(error),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err)
    );

    function automatic logic [31:0] init_word(int i);
        return (i >= 'h400 && i < 'h420) ? 32'hA0000000 + 32'(i - 'h400) : 32'hC0DE0000 + 32'(i);
    endfunction

    task automatic chk(string name, logic [1023:0] got, logic [1023:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // responder: decides ack/err at the falling edge; writes commit when the ack is granted
    always @(negedge clk) begin
        if (!resetn) begin
            m_ack = 0;
            m_err = 0;
            prev_req = 0;
            prev_ack = 0;
        end else begin
            logic go, e;
            if (m_req) req_seen++;
            if (prev_req && m_req && !prev_ack)
                chk("stall_hold", {m_addr, m_we, m_wdata}, prev_bus);
            go = m_req && (mode == 0 || (mode == 1 && $urandom_range(0, 2) != 0));
            e = m_req && m_addr == err_addr;
            if (go && !e) begin
                chk("beat_addr_we", {m_addr, m_we}, {cur_base + 32'(4 * beats_seen), cur_we});
                if (m_we) mem[m_addr[13:2]] = m_wdata;
                beats_seen++;
            end
            m_rdata = mem[m_addr[13:2]];
            m_ack = go;
            m_err = e;
            prev_req = m_req;
            prev_ack = go || e;
            prev_bus = {m_addr, m_we, m_wdata};
        end
    end

    initial begin
        vec_t v;
        int n;
        logic got;
        for (int i = 0; i < 4096; i++) mem[i] = init_word(i);
        for (int i = 0; i < 32; i++) tx_data[i*32 +: 32] = 32'(i);
        vecs[0] = '{1'b1, 1'b0, 32'h1000, 32'h0,    0, '1,          33,  1'b0, 32};
        vecs[1] = '{1'b0, 1'b1, 32'h0,    32'h2000, 1, '1,          -1,  1'b0, 32};
        vecs[2] = '{1'b1, 1'b1, 32'h1000, 32'h2000, 0, '1,          33,  1'b0, 32};
        vecs[3] = '{1'b1, 1'b0, 32'h3000, 32'h0,    0, 32'h3014,    7,   1'b1, 5};
        vecs[4] = '{1'b1, 1'b0, 32'h1000, 32'h0,    0, '1,          33,  1'b0, 32};
        vecs[5] = '{1'b1, 1'b0, 32'h1002, 32'h0,    0, '1,          1,   1'b1, 0};
        vecs[6] = '{1'b0, 1'b1, 32'h0,    32'h2001, 0, '1,          1,   1'b1, 0};
        vecs[7] = '{1'b1, 1'b0, 32'h1000, 32'h0,    2, '1,          256, 1'b1, 0};
        vecs[8] = '{1'b0, 1'b1, 32'h0,    32'h2000, 0, '1,          33,  1'b0, 32};

        #12;
        chk("rst_flags", {idle, done, error, m_req, m_we}, 5'b10000);
        chk("rst_bus", {m_addr, m_wdata}, 64'h0);
        chk("rst_rx_data", rx_data, '0);
        @(negedge clk);
        resetn = 1;

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            @(negedge clk);
            mode = v.mode;
            err_addr = v.err_addr;
            cur_we = !v.rx;
            cur_base = v.rx ? v.rx_addr : v.tx_addr;
            beats_seen = 0;
            req_seen = 0;
            rx_address = v.rx_addr;
            tx_address = v.tx_addr;
            rx_start = v.rx;
            tx_start = v.tx;
            @(posedge clk);
            #1;
            rx_start = 0;
            tx_start = 0;
            @(negedge clk);
            chk("c1_idle", idle, 0);
            chk("c1_req", m_req, v.exp_cyc != 1);
            if (v.exp_cyc != 1) chk("c1_err_clear", error, 0);
            n = 1;
            got = 0;
            while (!got && n < 400) begin
                if (done) got = 1;
                else begin
                    @(negedge clk);
                    n++;
                end
            end
            chk("done_seen", got, 1);
            if (v.exp_cyc > 0) chk("done_cycle", n, v.exp_cyc);
            chk("error", error, v.exp_err);
            chk("beats", beats_seen, v.beats);
            if (v.exp_cyc == 1) chk("no_req", req_seen, 0);
            if (v.rx)
                for (int b = 0; b < v.beats; b++)
                    exp_rx[b*32 +: 32] = init_word(int'(v.rx_addr[13:2]) + b);
            chk("rx_data", rx_data, exp_rx);
            @(negedge clk);
            chk("idle_after", idle, 1);
            chk("single_done", done, 0);
            if (i == 0) begin
                chk("rd_lo", rx_data[31:0], 32'hA0000000);
                chk("rd_hi", rx_data[1023:992], 32'hA000001F);
            end
            if (i == 1)
                for (int w = 0; w < 32; w++) chk("wr_mem", mem['h800 + w], 32'(w));
            if (i == 3) begin
                chk("err_beat4_new", rx_data[159:128], 32'hC0DE0C04);
                chk("err_beat5_kept", rx_data[191:160], 32'hA0000005);
            end
        end

        @(negedge clk);
        mode = 0;
        err_addr = '1;
        cur_we = 0;
        cur_base = 32'h1000;
        beats_seen = 0;
        rx_address = 32'h1000;
        rx_start = 1;
        @(posedge clk);
        #1;
        rx_start = 0;
        n = 0;
        while (m_addr != 32'h1028 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_beat10", m_addr, 32'h1028);
        #2;
        resetn = 0;
        #1;
        chk("async_rst_flags", {idle, done, error, m_req, m_we}, 5'b10000);
        chk("async_rst_addr", m_addr, 32'h0);
        chk("async_rst_rx", rx_data, '0);
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        chk("post_rst_idle", {idle, m_req}, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dma_engine.md
# dma_engine

Memory-side responder for the accelerator's 1024-bit DMA interface. It accepts single-block read (rx) and write (tx) requests from the accelerator control FSM. Each block is split into 32-bit beats on a simple request/acknowledge memory bus, and completion is reported back with `done`, `idle` and `error`. The block sits between the accelerator's `dma_*` ports and the memory/interconnect, serving exactly one transfer at a time.

## Interface
- `DATA_W`, default 1024: block width in bits. Must be a multiple of `BUS_W`.
- `BUS_W`, default 32: memory bus data width.
- `TIMEOUT`, default 255: maximum number of cycles a single beat may wait for `m_ack` or `m_err`.
- One clock. Reset is asynchronous and active-low.
- `clk`, input, 1: clock. All logic is clocked on the rising edge.
- `resetn`, input, 1: asynchronous active-low reset.
- `rx_start`, input, 1: request a read from memory into `rx_data`.
- `rx_address`, input, 32: byte base address for the read.
- `rx_data`, output, `DATA_W`: assembled read block.
- `tx_start`, input, 1: request a write of `tx_data` to memory.
- `tx_address`, input, 32: byte base address for the write.
- `tx_data`, input, `DATA_W`: block to write. Must be held stable for the whole transfer.
- `done`, output, 1: one-cycle pulse when a transfer completes or aborts.
- `idle`, output, 1: high only when the engine is ready to accept a new start.
- `error`, output, 1: sticky error flag for the last transfer.
- `m_req`, output, 1: bus beat request.
- `m_we`, output, 1: 1 = write beat, 0 = read beat.
- `m_addr`, output, 32: beat byte address.
- `m_wdata`, output, `BUS_W`: write beat data.
- `m_ack`, input, 1: beat accepted or read data valid.
- `m_rdata`, input, `BUS_W`: read beat data.
- `m_err`, input, 1: bus error for the current beat.

## Operation
- `BEATS` = `DATA_W`/`BUS_W` (32 with the defaults).
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - `rx_start` → READ. `tx_start` → WRITE.
  - Both starts high in the same cycle: rx wins and tx is dropped.
  - Starts are level-sampled only in IDLE and ignored in every other state. The requester must deassert start before the engine returns to IDLE.
- On accept:
  - Latch the base address.
  - Clear `error` and the beat counter `k`.
  - Clear the timeout counter.
- Misaligned base (`addr[1:0]` != 0):
  - No bus traffic.
  - Go directly to DONE with `error`=1.
- Beat addressing:
  - Beat `k` uses `m_addr` = base + 4k.
  - Data is little-endian by beat: beat `k` maps to bits [`BUS_W`·k+31 : `BUS_W`·k].
- READ:
  - `m_req`=1, `m_we`=0.
  - On a cycle with `m_ack`=1, write `m_rdata` into the slice for beat `k`, then increment `k`.
  - After beat `BEATS`-1 → DONE.
- WRITE:
  - `m_req`=1, `m_we`=1, `m_wdata` = `tx_data` slice for beat `k`.
  - The `m_ack` rule is the same as READ.
- Bus holding rules:
  - While `m_req`=1 and no ack, `m_addr`/`m_we`/`m_wdata` hold stable.
  - `m_req` stays high across beats; the next beat's address appears the cycle after the ack.
- Abort conditions:
  - `m_err`=1 while `m_req`=1, or the timeout counter reaching `TIMEOUT` → DONE with `error`=1.
  - `m_err` takes priority over `m_ack` in the same cycle.
  - `rx_data` beats already written are retained; later beats are unchanged.
- DONE:
  - `done`=1 for exactly this one cycle.
  - Unconditionally → IDLE.
- `error` holds its value until the next accepted start.
- `rx_data` holds its value until overwritten by a later read beat. A tx transfer never modifies it.

## Timing
- Reset values:
  - State IDLE.
  - `idle`=1; `done`, `error`, `m_req`, `m_we` = 0.
  - `m_addr`, `m_wdata`, `rx_data` = 0.
- Reset asserted mid-transfer: outputs go to reset values immediately (asynchronous) and the transfer is lost.
- Start sampled at edge 0:
  - From cycle 1: `idle`=0 and `m_req`=1 with beat 0.
  - The requester may wait on `~idle` and then on `done`.
- With `m_ack` held high:
  - Beats occupy cycles 1..`BEATS` (32).
  - `done` is high in cycle 33 and `idle` returns to 1 in cycle 34.
  - Throughput is one beat per cycle.
- Each wait cycle without `m_ack`/`m_err` adds one cycle.
- `rx_data` is complete and valid in the `done` cycle.
- Misaligned start: `done` in cycle 1, `m_req` never asserted.
- Timeout counter:
  - Counts cycles of the current beat with `m_req`=1 and no response.
  - Resets on each ack.
  - Abort occurs in the cycle the count reaches `TIMEOUT`, so `done` is `TIMEOUT`+1 cycles after the beat began.

## Test plan
- **Read, ack always high.** `rx_start`, address 0x1000; memory word at 0x1000+4k = k+0xA0000000.
  - Required: `m_addr` steps 0x1000..0x107C.
  - Required: `rx_data` bits [31:0]=0xA0000000 and bits [1023:992]=0xA000001F.
  - Required: `done` pulses in cycle 33, `error`=0.
- **Write with random ack stalls.** `tx_address` 0x2000, `tx_data` = {32 words 0..31}.
  - Required: memory holds word k at 0x2000+4k.
  - Required: bus outputs stay stable during every stall.
- **Simultaneous `rx_start` and `tx_start`.**
  - Required: only read beats appear (`m_we`=0), and exactly one `done`.
- **`m_err` on beat 5 of a read.**
  - Required: `done` in the cycle after the error, `error`=1.
  - Required: beats 0–4 of `rx_data` updated, beats 5–31 unchanged.
  - Required: the next good transfer clears `error`.
- **Misaligned address 0x1002.**
  - Required: `m_req` stays 0, `done` in cycle 1, `error`=1.
- **Timeout and reset.** No `m_ack` with `TIMEOUT`=255.
  - Required: `done` with `error`=1 at 256 cycles.
  - Then, `resetn` low during a later transfer's beat 10: required `m_req`=0 and `idle`=1 immediately.
